// File: rtl/reset_sequencer.sv
// Staged reset for the prescaled core clock domain: peripherals release first, then the core,
// once lock has held long enough; re-asserts on lock loss, debounced button or software request.
module reset_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int DEBOUNCE    = 40000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    input  logic       btn_rst,
    input  logic       sw_rst_req,
    output logic       periph_rst,
    output logic       core_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] loss_count
);
    localparam int SEQ_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW      = $clog2(SEQ_MAX + 1);
    localparam int DW      = $clog2(DEBOUNCE + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        PERIPH,
        RUN
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic          btn_meta_q;
    logic          btn_s_q;
    logic          btn_db_q;
    logic          btn_db_d;
    logic [DW-1:0] db_cnt_q;
    logic [DW-1:0] db_cnt_d;
    state_t        state_q;
    logic [CW-1:0] seq_cnt_q;
    logic          periph_rst_q;
    logic          core_rst_q;
    logic          ready_q;
    logic          lock_lost_q;
    logic [7:0]    loss_count_q;
    logic          abort;

    assign abort = !locked || btn_db_q;

    // A mismatch must persist DEBOUNCE consecutive cycles before btn_db follows btn_s.
    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        if (btn_s_q != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = btn_s_q;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            btn_db_q   <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            btn_meta_q <= btn_rst;
            btn_s_q    <= btn_meta_q;
            btn_db_q   <= btn_db_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_LOCK;
            seq_cnt_q    <= '0;
            periph_rst_q <= 1'b1;
            core_rst_q   <= 1'b1;
            ready_q      <= 1'b0;
        end else if (abort) begin
            state_q      <= WAIT_LOCK;
            seq_cnt_q    <= '0;
            periph_rst_q <= 1'b1;
            core_rst_q   <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    state_q   <= HOLD;
                    seq_cnt_q <= '0;
                end
                HOLD: begin
                    if (seq_cnt_q == HOLD_LAST) begin
                        state_q      <= PERIPH;
                        periph_rst_q <= 1'b0;
                        seq_cnt_q    <= '0;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + CW'(1);
                    end
                end
                PERIPH: begin
                    if (seq_cnt_q == GAP_LAST) begin
                        state_q    <= RUN;
                        core_rst_q <= 1'b0;
                        ready_q    <= 1'b1;
                        seq_cnt_q  <= '0;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + CW'(1);
                    end
                end
                RUN: begin
                    // Lock is known good here, so restart straight from HOLD.
                    if (sw_rst_req) begin
                        state_q      <= HOLD;
                        seq_cnt_q    <= '0;
                        periph_rst_q <= 1'b1;
                        core_rst_q   <= 1'b1;
                        ready_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= WAIT_LOCK;
                end
            endcase
        end
    end

    // Only a lock drop observed while running counts; button aborts do not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_lost_q  <= 1'b0;
            loss_count_q <= '0;
        end else if (state_q == RUN && !locked) begin
            lock_lost_q  <= 1'b1;
            loss_count_q <= sat_inc8(loss_count_q);
        end
    end

    assign periph_rst = periph_rst_q;
    assign core_rst   = core_rst_q;
    assign ready      = ready_q;
    assign lock_lost  = lock_lost_q;
    assign loss_count = loss_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: models the release schedule as elapsed cycles since the last
// sequence start and the debouncer as a window of recent synchronised button samples.
module tb_reset_sequencer;
    localparam int H = 16;
    localparam int G = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic       btn_rst;
    logic       sw_rst_req;
    logic       periph_rst;
    logic       core_rst;
    logic       ready;
    logic       lock_lost;
    logic [7:0] loss_count;

    int n_vec = 0;
    int n_mis = 0;

    // age = cycles since the sequence started (-1 while waiting for a clean lock).
    int age;
    bit m_db, m_s1, m_s2, m_lost;
    int m_cnt;
    bit hist[$];

    reset_sequencer #(
        .HOLD_CYCLES(H),
        .STAGE_GAP  (G),
        .DEBOUNCE   (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .locked    (locked),
        .btn_rst   (btn_rst),
        .sw_rst_req(sw_rst_req),
        .periph_rst(periph_rst),
        .core_rst  (core_rst),
        .ready     (ready),
        .lock_lost (lock_lost),
        .loss_count(loss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] exp_vec();
        logic [7:0] c;
        c = m_cnt[7:0];
        return {age < H, age < H + G, age >= H + G, m_lost, c};
    endfunction

    function automatic logic [11:0] got_vec();
        return {periph_rst, core_rst, ready, lock_lost, loss_count};
    endfunction

    function automatic void model_reset();
        age = -1;
        m_db = 0; m_s1 = 0; m_s2 = 0; m_lost = 0;
        m_cnt = 0;
        hist.delete();
    endfunction

    function automatic void model_edge(input bit lk, input bit sw, input bit bt);
        bit abort, was_run, all_eq;
        abort   = !lk || m_db;
        was_run = (age >= H + G);
        if (was_run && !lk) begin
            m_lost = 1;
            if (m_cnt < 255) m_cnt++;
        end
        if (abort)               age = -1;
        else if (age < 0)        age = 0;
        else if (was_run && sw)  age = 0;
        else if (age < 1000)     age++;
        hist.push_back(m_s2);
        if (hist.size() > D) void'(hist.pop_front());
        if (hist.size() == D) begin
            all_eq = 1;
            foreach (hist[i]) if (hist[i] != hist[0]) all_eq = 0;
            if (all_eq && hist[0] != m_db) m_db = hist[0];
        end
        m_s2 = m_s1;
        m_s1 = bt;
    endfunction

    task automatic step(input bit lk, input bit sw, input bit bt);
        locked = lk; sw_rst_req = sw; btn_rst = bt;
        @(posedge clk);
        model_edge(lk, sw, bt);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; locked = 1'b0; sw_rst_req = 1'b0; btn_rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic bring_up();
        repeat (H + G + 2) step(1, 0, 0);
    endtask

    task automatic test_reset();
        int pf, cf;
        rst = 1'b1; locked = 1'b0; sw_rst_req = 1'b0; btn_rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (got_vec() !== 12'hC00) begin
            n_mis++; $display("FAIL reset_values got=%h want=%h", got_vec(), 12'hC00);
        end
        rst = 1'b0;
        pf = -1; cf = -1;
        for (int e = 1; e <= 35; e++) begin
            step(e >= 10, (e < 28) ? bit'($urandom_range(0, 1)) : 1'b0, 0);
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_mis++; $display("FAIL bringup e=%0d got=%h want=%h", e, got_vec(), exp_vec());
            end
            if (!periph_rst && pf < 0) pf = e;
            if (!core_rst && cf < 0) cf = e;
        end
        n_vec++;
        if (pf != 26) begin n_mis++; $display("FAIL periph_release_edge got=%0d want=26", pf); end
        n_vec++;
        if (cf != 30) begin n_mis++; $display("FAIL core_release_edge got=%0d want=30", cf); end
    endtask

    task automatic test_lock_drop_hold();
        int pf;
        do_reset();
        repeat (9) step(1, 0, 0);
        step(0, 0, 0);
        n_vec++;
        if (periph_rst !== 1'b1) begin
            n_mis++; $display("FAIL hold_drop_periph got=%b want=1", periph_rst);
        end
        pf = -1;
        for (int i = 0; i < 25; i++) begin
            step(1, 0, 0);
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_mis++; $display("FAIL hold_drop i=%0d got=%h want=%h", i, got_vec(), exp_vec());
            end
            if (!periph_rst && pf < 0) pf = i;
        end
        n_vec++;
        if (pf != 16) begin n_mis++; $display("FAIL hold_restart_delay got=%0d want=16", pf); end
        n_vec++;
        if (loss_count !== 8'd0) begin
            n_mis++; $display("FAIL hold_loss_count got=%0d want=0", loss_count);
        end
    endtask

    task automatic test_lock_loss_run();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            bring_up();
            n_vec++;
            if (ready !== 1'b1) begin
                n_mis++; $display("FAIL loss_run_ready i=%0d got=%b want=1", i, ready);
            end
            step(0, 0, 0);
            n_vec++;
            if ({periph_rst, core_rst, ready} !== 3'b110) begin
                n_mis++; $display("FAIL loss_abort i=%0d got=%b want=110", i, {periph_rst, core_rst, ready});
            end
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_mis++; $display("FAIL loss_model i=%0d got=%h want=%h", i, got_vec(), exp_vec());
            end
            repeat ($urandom_range(0, 2)) step(0, 0, 0);
        end
        n_vec++;
        if ({lock_lost, loss_count} !== 9'h1FF) begin
            n_mis++; $display("FAIL loss_saturate got=%b/%0d want=1/255", lock_lost, loss_count);
        end
        do_reset();
        n_vec++;
        if ({lock_lost, loss_count} !== 9'h000) begin
            n_mis++; $display("FAIL loss_cleared got=%b/%0d want=0/0", lock_lost, loss_count);
        end
    endtask

    task automatic test_sw_req();
        int pf, cf;
        bit sw;
        do_reset();
        repeat (6) step(0, bit'($urandom_range(0, 1)), 0);
        bring_up();
        repeat ($urandom_range(0, 5)) step(1, 0, 0);
        step(1, 1, 0);
        n_vec++;
        if ({periph_rst, core_rst, ready} !== 3'b110) begin
            n_mis++; $display("FAIL sw_assert got=%b want=110", {periph_rst, core_rst, ready});
        end
        pf = -1; cf = -1;
        for (int i = 1; i <= 24; i++) begin
            sw = (i <= 19) ? bit'($urandom_range(0, 1)) : 1'b0;
            step(1, sw, 0);
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_mis++; $display("FAIL sw_seq i=%0d got=%h want=%h", i, got_vec(), exp_vec());
            end
            if (!periph_rst && pf < 0) pf = i;
            if (!core_rst && cf < 0) cf = i;
        end
        n_vec++;
        if (pf != 16) begin n_mis++; $display("FAIL sw_periph_delay got=%0d want=16", pf); end
        n_vec++;
        if (cf != 20) begin n_mis++; $display("FAIL sw_core_delay got=%0d want=20", cf); end
    endtask

    task automatic test_button();
        do_reset();
        bring_up();
        for (int i = 0; i < 15; i++) begin
            step(1, 0, i < 3);
            n_vec++;
            if (ready !== 1'b1 || got_vec() !== exp_vec()) begin
                n_mis++; $display("FAIL btn_glitch i=%0d got=%h want=%h", i, got_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1);
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_mis++; $display("FAIL btn_press i=%0d got=%h want=%h", i, got_vec(), exp_vec());
            end
            if (i == 5) begin
                n_vec++;
                if ({periph_rst, ready} !== 2'b01) begin
                    n_mis++; $display("FAIL btn_early got=%b want=01", {periph_rst, ready});
                end
            end
            if (i == 6) begin
                n_vec++;
                if ({periph_rst, core_rst, ready} !== 3'b110) begin
                    n_mis++; $display("FAIL btn_assert got=%b want=110", {periph_rst, core_rst, ready});
                end
            end
        end
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0);
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_mis++; $display("FAIL btn_release i=%0d got=%h want=%h", i, got_vec(), exp_vec());
            end
        end
        n_vec++;
        if ({ready, lock_lost, loss_count} !== 10'h200) begin
            n_mis++; $display("FAIL btn_final got=%b/%b/%0d want=1/0/0", ready, lock_lost, loss_count);
        end
    endtask

    task automatic test_simultaneous();
        int pf;
        do_reset();
        bring_up();
        step(0, 1, 0);
        n_vec++;
        if ({periph_rst, core_rst, ready, lock_lost, loss_count} !== 12'hD01) begin
            n_mis++; $display("FAIL simul_abort got=%h want=%h", got_vec(), 12'hD01);
        end
        pf = -1;
        for (int i = 1; i <= 25; i++) begin
            step(1, 0, 0);
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_mis++; $display("FAIL simul_seq i=%0d got=%h want=%h", i, got_vec(), exp_vec());
            end
            if (!periph_rst && pf < 0) pf = i;
        end
        n_vec++;
        if (pf != 17) begin n_mis++; $display("FAIL simul_via_wait_lock got=%0d want=17", pf); end
    endtask

    task automatic test_random();
        bit lk, sw, bt;
        do_reset();
        bt = 0;
        for (int n = 0; n < 3000; n++) begin
            lk = ($urandom_range(0, 39) != 0);
            sw = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) bt = ~bt;
            step(lk, sw, bt);
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_mis++; $display("FAIL random n=%0d got=%h want=%h", n, got_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; locked = 1'b0; btn_rst = 1'b0; sw_rst_req = 1'b0;
        test_reset();
        test_lock_drop_hold();
        test_lock_loss_run();
        test_sw_req();
        test_button();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
